// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared phase encoding, default 640x480@60 timing and sync
//               polarity constants for the VGA raster timing block.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // 640x480@60 Hz from a 25.175 MHz pixel clock
    localparam int c_h_active = 640;
    localparam int c_h_front  = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_back   = 48;
    localparam int c_v_active = 480;
    localparam int c_v_front  = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_back   = 33;

    localparam logic c_sync_active_low  = 1'b0;
    localparam logic c_sync_active_high = 1'b1;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: wrapping position counter plus the
//               ACTIVE/FRONT/SYNC/BACK phase tracker for that axis.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter  int ACTIVE  = c_h_active,
    parameter  int FRONT   = c_h_front,
    parameter  int SYNC    = c_h_sync,
    parameter  int BACK    = c_h_back,
    localparam int c_total = ACTIVE + FRONT + SYNC + BACK,
    localparam int c_width = $clog2(c_total)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic [c_width-1:0] o_count,
    output phase_t             o_phase,
    output logic               o_wrap
);

    localparam logic [c_width-1:0] c_last       = c_width'(c_total - 1);
    localparam logic [c_width-1:0] c_active_end = c_width'(ACTIVE - 1);
    localparam logic [c_width-1:0] c_front_end  = c_width'(ACTIVE + FRONT - 1);
    localparam logic [c_width-1:0] c_sync_end   = c_width'(ACTIVE + FRONT + SYNC - 1);

    logic [c_width-1:0] r_count;
    phase_t             r_phase;

    // Phase moves on the same edge the count crosses into the next region
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
        end else if (i_en) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end

            case (r_phase)
                PH_ACTIVE: if (r_count == c_active_end) r_phase <= PH_FRONT;
                PH_FRONT:  if (r_count == c_front_end)  r_phase <= PH_SYNC;
                PH_SYNC:   if (r_count == c_sync_end)   r_phase <= PH_BACK;
                PH_BACK:   if (r_count == c_last)       r_phase <= PH_ACTIVE;
                default:                                r_phase <= PH_ACTIVE;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_phase = r_phase;
    assign o_wrap  = i_en && (r_count == c_last);

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_generator
// Description : VGA raster timing: HSYNC/VSYNC, active-video qualifier,
//               pixel coordinates and frame-start pulse, all registered.
//               Optional frame counter enabled by VGA_SYNC_FRAME_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_generator
    import vga_pkg::*;
#(
    parameter  int   H_ACTIVE  = c_h_active,
    parameter  int   H_FRONT   = c_h_front,
    parameter  int   H_SYNC    = c_h_sync,
    parameter  int   H_BACK    = c_h_back,
    parameter  int   V_ACTIVE  = c_v_active,
    parameter  int   V_FRONT   = c_v_front,
    parameter  int   V_SYNC    = c_v_sync,
    parameter  int   V_BACK    = c_v_back,
    parameter  logic SYNC_POL  = c_sync_active_low,
    localparam int   c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int   c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int   c_h_width = $clog2(c_h_total),
    localparam int   c_v_width = $clog2(c_v_total)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_active,
    output logic [c_h_width-1:0] o_x,
    output logic [c_v_width-1:0] o_y,
    output logic                 o_frame_start,
    output logic [15:0]          o_frame
);

    logic [c_h_width-1:0] w_h_count;
    logic [c_v_width-1:0] w_v_count;
    phase_t               w_h_phase;
    phase_t               w_v_phase;
    logic                 w_h_wrap;
    logic                 w_v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (1'b1),
        .o_count (w_h_count),
        .o_phase (w_h_phase),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_h_wrap),
        .o_count (w_v_count),
        .o_phase (w_v_phase),
        .o_wrap  (w_v_wrap)
    );

    logic                 r_at_origin;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_active;
    logic [c_h_width-1:0] r_x;
    logic [c_v_width-1:0] r_y;
    logic                 r_frame_start;

    // r_at_origin mirrors "counters sit at (0,0)": true after reset and
    // after the last pixel of a frame, avoiding a two-axis compare.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_at_origin   <= 1'b1;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_active      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_at_origin   <= w_v_wrap;
            r_hsync       <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_active      <= (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
            r_x           <= w_h_count;
            r_y           <= w_v_count;
            r_frame_start <= r_at_origin;
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_active      = r_active;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] r_frame;

    // Increments on the same edge that registers the frame-start pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame <= '0;
        end else if (r_at_origin) begin
            r_frame <= r_frame + 16'd1;
        end
    end

    assign o_frame = r_frame;
`else
    assign o_frame = 16'd0;
`endif

endmodule : vga_sync_generator
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_generator
// Description : Directed self-checking bench for vga_sync_generator using a
//               default 640x480 instance and a 5x5 active-high instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_generator;

    logic clk;
    logic rst;
    logic rst_s;

    logic        hsync, vsync, active, frame_start;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] frame;

    logic        hsync_s, vsync_s, active_s, frame_start_s;
    logic [2:0]  x_s;
    logic [2:0]  y_s;
    logic [15:0] frame_s;

    int checks = 0;
    int errors = 0;

    vga_sync_generator dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_active      (active),
        .o_x           (x),
        .o_y           (y),
        .o_frame_start (frame_start),
        .o_frame       (frame)
    );

    vga_sync_generator #(
        .H_ACTIVE (2), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
        .V_ACTIVE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_POL (1'b1)
    ) dut_s (
        .i_clk         (clk),
        .i_rst         (rst_s),
        .o_hsync       (hsync_s),
        .o_vsync       (vsync_s),
        .o_active      (active_s),
        .o_x           (x_s),
        .o_y           (y_s),
        .o_frame_start (frame_start_s),
        .o_frame       (frame_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int p, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at p=%0d: observed=%0d expected=%0d", tag, p, obs, exp);
        end
    endtask

    function automatic int exp_frame(input int p, input int frame_len);
`ifdef VGA_SYNC_FRAME_COUNT_EN
        return ((p / frame_len) + 1) % 65536;
`else
        return 0;
`endif
    endfunction

    // Default 640x480: bench model of the position presented at p
    task automatic check_def(input int p);
        int ex, ey;
        ex = p % 800;
        ey = (p / 800) % 525;
        chk("def_x",      p, 32'(x),           ex);
        chk("def_y",      p, 32'(y),           ey);
        chk("def_active", p, 32'(active),      (ex < 640 && ey < 480) ? 1 : 0);
        chk("def_hsync",  p, 32'(hsync),       (ex >= 656 && ex < 752) ? 0 : 1);
        chk("def_vsync",  p, 32'(vsync),       (ey >= 490 && ey < 492) ? 0 : 1);
        chk("def_fstart", p, 32'(frame_start), (ex == 0 && ey == 0) ? 1 : 0);
        chk("def_frame",  p, 32'(frame),       exp_frame(p, 420000));
    endtask

    // 2/1/1/1 per axis, active-high syncs: 5-pixel lines, 25-pixel frames
    task automatic check_small(input int p);
        int ex, ey;
        ex = p % 5;
        ey = (p / 5) % 5;
        chk("sm_x",      p, 32'(x_s),           ex);
        chk("sm_y",      p, 32'(y_s),           ey);
        chk("sm_active", p, 32'(active_s),      (ex < 2 && ey < 2) ? 1 : 0);
        chk("sm_hsync",  p, 32'(hsync_s),       (ex == 3) ? 1 : 0);
        chk("sm_vsync",  p, 32'(vsync_s),       (ey == 3) ? 1 : 0);
        chk("sm_fstart", p, 32'(frame_start_s), (ex == 0 && ey == 0) ? 1 : 0);
        chk("sm_frame",  p, 32'(frame_s),       exp_frame(p, 25));
    endtask

    task automatic check_def_reset(input int p);
        chk("rst_def_active", p, 32'(active),      0);
        chk("rst_def_x",      p, 32'(x),           0);
        chk("rst_def_y",      p, 32'(y),           0);
        chk("rst_def_fstart", p, 32'(frame_start), 0);
        chk("rst_def_hsync",  p, 32'(hsync),       1);
        chk("rst_def_vsync",  p, 32'(vsync),       1);
        chk("rst_def_frame",  p, 32'(frame),       0);
    endtask

    task automatic check_small_reset(input int p);
        chk("rst_sm_active", p, 32'(active_s),      0);
        chk("rst_sm_x",      p, 32'(x_s),           0);
        chk("rst_sm_y",      p, 32'(y_s),           0);
        chk("rst_sm_fstart", p, 32'(frame_start_s), 0);
        chk("rst_sm_hsync",  p, 32'(hsync_s),       0);
        chk("rst_sm_vsync",  p, 32'(vsync_s),       0);
        chk("rst_sm_frame",  p, 32'(frame_s),       0);
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_def_reset(-1);
        check_small_reset(-1);

        // Small instance: three-plus frames, every pixel
        rst_s = 1'b0;
        for (int p = 0; p < 80; p++) begin
            @(posedge clk);
            #1;
            check_small(p);
        end
        check_def_reset(-1);

        // Default instance: two full lines plus part of line 2
        rst = 1'b0;
        for (int p = 0; p <= 1900; p++) begin
            @(posedge clk);
            #1;
            check_def(p);
        end

        // Mid-line reset at x=300, y=2
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_def_reset(1901);
        rst = 1'b0;
        for (int p = 0; p < 20; p++) begin
            @(posedge clk);
            #1;
            check_def(p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vga_sync_generator
`default_nettype wire

// File: doc/vga_sync_generator.md
# vga_sync_generator

- Raster timing stage directly upstream of the colour/image generator in the VGA pipeline.
- Runs horizontal and vertical pixel counters and decodes them into HSYNC, VSYNC and an active-video qualifier.
- The active-video qualifier drives the image generator's `i_active`; the pixel coordinates are for downstream pixel sources.
- Default parameters give 640x480@60 Hz from a 25.175 MHz pixel clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- i_clk  input  1  pixel clock; sole clock
- i_rst  input  1  reset, synchronous, active-high
- o_hsync  output  1  horizontal sync, asserted level = SYNC_POL
- o_vsync  output  1  vertical sync, asserted level = SYNC_POL
- o_active  output  1  high while the pixel is inside the visible area; feeds image generator `i_active`
- o_x  output  $clog2(H_TOTAL)  current pixel column
- o_y  output  $clog2(V_TOTAL)  current line
- o_frame_start  output  1  one-cycle pulse at pixel (0,0)
- o_frame  output  16  frame counter (see Configuration)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Horizontal counter h: 0..H_TOTAL-1, increments every cycle, wraps to 0.
- Vertical counter v: 0..V_TOTAL-1, increments only on the h wrap cycle, wraps to 0 on its own last line.
- Each axis tracks a phase FSM (phase_t: ACTIVE, FRONT, SYNC, BACK):
  - ACTIVE, count < ACTIVE
  - FRONT, count < ACTIVE+FRONT
  - SYNC, count < ACTIVE+FRONT+SYNC
  - BACK otherwise
- Phase transitions happen on the same edge the counter crosses each boundary; BACK -> ACTIVE on wrap.
- Decode:
  - o_active = (h phase ACTIVE) and (v phase ACTIVE)
  - o_hsync asserted iff h phase SYNC (656 <= h < 752 default)
  - o_vsync asserted iff v phase SYNC (490 <= v < 492 default); spans full lines, changes aligned with h = 0
- o_x/o_y track the raw counters in all phases, including blanking.
- o_frame_start = 1 iff h = 0 and v = 0.
- Counters are exactly $clog2(TOTAL) wide; no arithmetic exceeds that width; wrap by compare-to-TOTAL-1, never by overflow.
- Reset (i_rst = 1 at an edge), any time, including mid-line:
  - h, v = 0; both FSMs to ACTIVE
  - o_active = 0, o_frame_start = 0, o_x = 0, o_y = 0, o_frame = 0
  - o_hsync = o_vsync = ~SYNC_POL (deasserted)

## Timing
- All outputs are registered and mutually aligned: each output reflects the same (h, v) pair in the same cycle. No skew between o_active, syncs and coordinates.
- Output latency: edge k after reset release (k = 1 first) presents position p = k-1, i.e. o_x = p mod H_TOTAL, o_y = (p / H_TOTAL) mod V_TOTAL.
- First edge after release: o_active = 1, o_x = 0, o_y = 0, o_frame_start = 1.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL*V_TOTAL cycles (420000 default).
- Image generator sees `i_active` rise exactly at o_x = 0 on each visible line and fall at o_x = H_ACTIVE.

## Configuration
- Macro: VGA_SYNC_FRAME_COUNT_EN.
- Defined:
  - o_frame increments by 1 on each cycle where o_frame_start is registered high; the first frame after reset reads 1.
  - Wraps 0xFFFF -> 0.
  - Cleared by reset.
- Undefined: o_frame is tied to 0 and no counter logic is synthesised; the port list is unchanged.

## Structure
- Shared package vga_pkg:
  - phase_t enum
  - default timing localparams (640x480@60)
  - sync polarity constants
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical).
  - Parameters: ACTIVE/FRONT/SYNC/BACK.
  - Inputs: i_clk, i_rst, i_en.
  - Outputs: count, phase, wrap.
  - Horizontal instance: i_en = 1.
  - Vertical instance: i_en = horizontal wrap.
- Top level performs decode and output registering.

## Test plan
- Reset release, defaults -> edge 1: o_active = 1, o_x = 0, o_y = 0, o_frame_start = 1, syncs high; edge 641: o_active = 0, o_x = 640.
- Horizontal sync -> o_hsync low exactly for o_x 656..751 (96 cycles) on every line; line period 800 cycles.
- Vertical sync -> o_vsync low for o_y 490..491 (1600 cycles), rising/falling with o_x = 0; o_frame_start period 420000 cycles.
- Mid-frame reset at o_x = 300, o_y = 200 -> next edge: all outputs at reset values; edge after release: o_x = 0, o_y = 0, o_frame_start = 1.
- Small parameters (2/1/1/1 each axis, SYNC_POL = 1) -> line period 5, frame period 25; hsync high only at o_x = 3; o_x wraps 4 -> 0; o_y wraps 4 -> 0.
- VGA_SYNC_FRAME_COUNT_EN defined, 3 frames -> o_frame = 1, 2, 3 at successive frame starts; undefined -> o_frame = 0 throughout.
